// File: rtl/clock_reg_change_receiver.sv
// Receive side of a clock_reg_latch channel: qualifies the synchronised word as
// stable, detects real changes and hands each one out over valid/ready.
module clock_reg_change_receiver #(
  parameter int DATA_SIZE     = 32,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] sync_data_in,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 change_strobe,
  output logic                 overrun,
  input  logic                 overrun_clear
);

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);

  // Handshake: data_out is transferred on any edge where data_valid && data_ready.
  // data_valid is the FSM state (FULL) and is only raised by an accepted change.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e                 state_q;
  logic [DATA_SIZE-1:0]   prev_in_q;
  logic [DATA_SIZE-1:0]   accepted_q;
  logic [DATA_SIZE-1:0]   data_out_q;
  logic [3:0]             stable_cnt_q;
  logic [3:0]             stable_cnt_d;
  logic                   change_strobe_q;
  logic                   overrun_q;
  logic                   qualify;

  assign qualify = (stable_cnt_q == STABLE_MAX) && (prev_in_q != accepted_q);

  // Saturating run-length of identical samples; never wraps.
  always_comb begin
    stable_cnt_d = 4'd0;
    if (sync_data_in == prev_in_q) begin
      stable_cnt_d = (stable_cnt_q == STABLE_MAX) ? stable_cnt_q : stable_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_in_q       <= '0;
      stable_cnt_q    <= 4'd0;
      accepted_q      <= '0;
      data_out_q      <= '0;
      state_q         <= EMPTY;
      change_strobe_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      prev_in_q       <= sync_data_in;
      stable_cnt_q    <= stable_cnt_d;
      change_strobe_q <= qualify;

      if (qualify) begin
        accepted_q <= prev_in_q;
        data_out_q <= prev_in_q;
      end

      case (state_q)
        EMPTY: begin
          if (qualify) state_q <= FULL;
        end
        FULL: begin
          if (data_ready && !qualify) state_q <= EMPTY;
        end
        default: state_q <= EMPTY;
      endcase

      // A set (overwrite of an unconsumed value) beats a simultaneous clear.
      if ((state_q == FULL) && !data_ready && qualify) begin
        overrun_q <= 1'b1;
      end else if (overrun_clear) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign data_out      = data_out_q;
  assign data_valid    = (state_q == FULL);
  assign change_strobe = change_strobe_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_clock_reg_change_receiver.sv
// Directed bench for clock_reg_change_receiver with default parameters.
module tb_clock_reg_change_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] sync_data_in;
  logic [31:0] data_out;
  logic        data_valid;
  logic        data_ready;
  logic        change_strobe;
  logic        overrun;
  logic        overrun_clear;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  clock_reg_change_receiver #(.DATA_SIZE(32), .STABLE_CYCLES(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .sync_data_in  (sync_data_in),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .change_strobe (change_strobe),
    .overrun       (overrun),
    .overrun_clear (overrun_clear)
  );

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    sync_data_in = 32'h0;
    data_ready = 1'b0;
    overrun_clear = 1'b0;

    // Reset and baseline
    step(2);
    check("rst_data", data_out, 32'h0);
    check("rst_valid", {31'b0, data_valid}, 32'h0);
    check("rst_strobe", {31'b0, change_strobe}, 32'h0);
    check("rst_overrun", {31'b0, overrun}, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("base_strobe", {31'b0, change_strobe}, 32'h0);
      check("base_valid", {31'b0, data_valid}, 32'h0);
    end
    check("base_data", data_out, 32'h0);

    // Basic change: visible after edge E+3
    sync_data_in = 32'h12345678;
    step(3);
    check("basic_early_valid", {31'b0, data_valid}, 32'h0);
    check("basic_early_strobe", {31'b0, change_strobe}, 32'h0);
    step();
    check("basic_data", data_out, 32'h12345678);
    check("basic_valid", {31'b0, data_valid}, 32'h1);
    check("basic_strobe", {31'b0, change_strobe}, 32'h1);
    step();
    check("basic_strobe_off", {31'b0, change_strobe}, 32'h0);
    check("basic_hold_valid", {31'b0, data_valid}, 32'h1);
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    check("basic_consumed", {31'b0, data_valid}, 32'h0);
    check("basic_data_kept", data_out, 32'h12345678);

    // Glitch rejection around accepted 0xA5A5A5A5
    sync_data_in = 32'hA5A5A5A5;
    step(4);
    check("glitch_base_data", data_out, 32'hA5A5A5A5);
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    check("glitch_base_consumed", {31'b0, data_valid}, 32'h0);
    sync_data_in = 32'hFFFF0000;
    for (int i = 0; i < 2; i++) begin
      step();
      check("glitch_strobe", {31'b0, change_strobe}, 32'h0);
    end
    sync_data_in = 32'hA5A5A5A5;
    for (int i = 0; i < 6; i++) begin
      step();
      check("glitch_strobe", {31'b0, change_strobe}, 32'h0);
      check("glitch_valid", {31'b0, data_valid}, 32'h0);
    end
    check("glitch_data", data_out, 32'hA5A5A5A5);

    // Overrun
    sync_data_in = 32'h1;
    step(4);
    check("ovr_first", data_out, 32'h1);
    check("ovr_first_flag", {31'b0, overrun}, 32'h0);
    sync_data_in = 32'h2;
    step(4);
    check("ovr_data", data_out, 32'h2);
    check("ovr_valid", {31'b0, data_valid}, 32'h1);
    check("ovr_set", {31'b0, overrun}, 32'h1);
    step(2);
    check("ovr_sticky", {31'b0, overrun}, 32'h1);
    overrun_clear = 1'b1;
    step();
    overrun_clear = 1'b0;
    check("ovr_cleared", {31'b0, overrun}, 32'h0);
    sync_data_in = 32'h5;
    step(3);
    check("ovr2_pre", {31'b0, overrun}, 32'h0);
    overrun_clear = 1'b1;
    step();
    overrun_clear = 1'b0;
    check("ovr2_set_wins", {31'b0, overrun}, 32'h1);
    check("ovr2_data", data_out, 32'h5);
    overrun_clear = 1'b1;
    step();
    overrun_clear = 1'b0;
    check("ovr2_cleared", {31'b0, overrun}, 32'h0);

    // Simultaneous ready and qualify
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    check("sim_drain", {31'b0, data_valid}, 32'h0);
    sync_data_in = 32'h3;
    step(4);
    check("sim_first", data_out, 32'h3);
    check("sim_first_valid", {31'b0, data_valid}, 32'h1);
    sync_data_in = 32'h4;
    step(3);
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    check("sim_valid", {31'b0, data_valid}, 32'h1);
    check("sim_data", data_out, 32'h4);
    check("sim_strobe", {31'b0, change_strobe}, 32'h1);
    check("sim_overrun", {31'b0, overrun}, 32'h0);

    // Reset mid-operation
    sync_data_in = 32'h7;
    step(4);
    check("mid_pre_data", data_out, 32'h7);
    check("mid_pre_overrun", {31'b0, overrun}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_data", data_out, 32'h0);
    check("mid_rst_valid", {31'b0, data_valid}, 32'h0);
    check("mid_rst_strobe", {31'b0, change_strobe}, 32'h0);
    check("mid_rst_overrun", {31'b0, overrun}, 32'h0);
    step(3);
    check("mid_early_valid", {31'b0, data_valid}, 32'h0);
    step();
    check("mid_reaccept_valid", {31'b0, data_valid}, 32'h1);
    check("mid_reaccept_data", data_out, 32'h7);
    check("mid_reaccept_strobe", {31'b0, change_strobe}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
